// File: rtl/dispatch_demux4.sv
// dispatch_demux4: one-to-four dispatch demultiplexer with a 2-entry FIFO per lane.
//
// A single producer pushes one tagged entry per cycle (in_valid/in_ready). The
// entry is routed by in_sel into one of four independent lane FIFOs. Each lane
// drains over its own out_valid[k]/out_ready[k] handshake. flush empties all
// lanes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous clear of all lane FIFOs
//   in_valid/in_ready input handshake; in_sel picks lane, in_data is payload
//   out_valid[3:0]    per-lane head valid
//   out_ready[3:0]    per-lane consumer takes head
//   out_data0..3      per-lane head payload (registered storage)
//   occ[7:0]          lane k occupancy (0..2) at bits [2k+1:2k]
module dispatch_demux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [7:0]       occ
);

  logic [WIDTH-1:0] mem_q [4][2];
  logic [WIDTH-1:0] mem_d [4][2];
  logic [3:0]       wptr_q, wptr_d;
  logic [3:0]       rptr_q, rptr_d;
  logic [1:0]       count_q [4];
  logic [1:0]       count_d [4];
  logic [3:0]       push, pop;

  // Handshake and status. in_ready depends only on in_sel and registered
  // counts, never on out_ready.
  always_comb begin
    in_ready = !rst && !flush && (count_q[in_sel] != 2'd2);
    out_valid = '0;
    occ       = '0;
    push      = '0;
    pop       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      out_valid[k]  = (count_q[k] != 2'd0);
      occ[2*k +: 2] = count_q[k];
      push[k]       = in_valid && in_ready && (in_sel == k[1:0]);
      pop[k]        = out_valid[k] && out_ready[k];
    end
  end

  // Pointer and count next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (push[k]) begin
        wptr_d[k] = ~wptr_q[k];
      end
      if (pop[k]) begin
        rptr_d[k] = ~rptr_q[k];
      end
      if (push[k] && !pop[k]) begin
        count_d[k] = count_q[k] + 2'd1;
      end else if (pop[k] && !push[k]) begin
        count_d[k] = count_q[k] - 2'd1;
      end
    end
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      for (int unsigned k = 0; k < 4; k++) begin
        count_d[k] = 2'd0;
      end
    end
  end

  // Storage next-state. A push into an empty lane also fills the idle slot, so
  // once a lane has been written its head never reads an unwritten entry.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (push[k]) begin
        mem_d[k][wptr_q[k]] = in_data;
        if (count_q[k] == 2'd0) begin
          mem_d[k][~wptr_q[k]] = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        count_q[k] <= 2'd0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_data0 = mem_q[0][rptr_q[0]];
  assign out_data1 = mem_q[1][rptr_q[1]];
  assign out_data2 = mem_q[2][rptr_q[2]];
  assign out_data3 = mem_q[3][rptr_q[3]];

endmodule

// File: tb/tb_dispatch_demux4.sv
module tb_dispatch_demux4;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0]       occ;

  int n_checks = 0;
  int n_fail   = 0;

  dispatch_demux4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [WIDTH-1:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int exp_next;
    int pushed;
    int got_cnt;
    logic do_push, do_pop;
    logic [WIDTH-1:0] pop_data;

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 32'h0;
    out_ready = 4'b0000;

    // Reset held two cycles with a pending request.
    tick();
    tick();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 4'b0000);
    check_eq("rst_occ", occ, 8'h00);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);

    // Routing to all four lanes.
    push(2'd0, 32'hA0);
    check_eq("lat1_valid0", out_valid, 4'b0001);
    push(2'd1, 32'hB1);
    push(2'd2, 32'hC2);
    push(2'd3, 32'hD3);
    check_eq("route_valid", out_valid, 4'b1111);
    check_eq("route_d0", out_data0, 32'hA0);
    check_eq("route_d1", out_data1, 32'hB1);
    check_eq("route_d2", out_data2, 32'hC2);
    check_eq("route_d3", out_data3, 32'hD3);
    check_eq("route_occ", occ, 8'b01010101);
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    check_eq("drain_occ", occ, 8'h00);

    // Full lane stall.
    push(2'd1, 32'h11);
    push(2'd1, 32'h22);
    check_eq("full_occ1", occ[3:2], 2'd2);
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'h33;
    #1;
    check_eq("full_in_ready", in_ready, 0);
    tick();
    check_eq("full_hold_occ", occ[3:2], 2'd2);
    check_eq("full_hold_d1", out_data1, 32'h11);
    in_sel = 2'd0;
    #1;
    check_eq("other_lane_ready", in_ready, 1);
    in_valid  = 1'b0;
    out_ready = 4'b0010;
    tick();
    check_eq("lane1_second", out_data1, 32'h22);
    tick();
    out_ready = 4'b0000;
    check_eq("lane1_empty", out_valid[1], 0);

    // Simultaneous push and pop at count 1.
    push(2'd2, 32'h5);
    check_eq("pp_pre_d2", out_data2, 32'h5);
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 32'h6;
    out_ready = 4'b0100;
    #1;
    check_eq("pp_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("pp_occ2", occ[5:4], 2'd1);
    check_eq("pp_d2", out_data2, 32'h6);
    tick();
    out_ready = 4'b0000;
    check_eq("pp_empty", out_valid[2], 0);

    // Streaming 1..8 into lane 3 with random consumer backpressure.
    exp_next = 1;
    pushed   = 0;
    got_cnt  = 0;
    for (int cyc = 0; cyc < 200 && got_cnt < 8; cyc++) begin
      in_valid  = (pushed < 8);
      in_sel    = 2'd3;
      in_data   = WIDTH'(pushed + 1);
      out_ready = {($urandom_range(0, 1) == 1), 3'b000};
      #1;
      do_push  = in_valid && in_ready;
      do_pop   = out_valid[3] && out_ready[3];
      pop_data = out_data3;
      if (do_pop) begin
        check_eq("stream_data", pop_data, 64'(exp_next));
        exp_next++;
        got_cnt++;
      end
      tick();
      if (do_push) pushed++;
    end
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    check_eq("stream_count", got_cnt, 8);
    check_eq("stream_empty", occ, 8'h00);

    // Flush with lanes 0 and 2 full and a request pending.
    push(2'd0, 32'hA);
    push(2'd0, 32'hB);
    push(2'd2, 32'hC);
    push(2'd2, 32'hD);
    check_eq("pre_flush_occ", occ, 8'h22);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'h77;
    #1;
    check_eq("flush_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_valid", out_valid, 4'b0000);
    check_eq("flush_occ", occ, 8'h00);
    push(2'd1, 32'h99);
    check_eq("post_flush_valid", out_valid, 4'b0010);
    check_eq("post_flush_d1", out_data1, 32'h99);

    // Reset mid-operation clears lanes.
    push(2'd3, 32'h44);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    check_eq("mid_rst_occ", occ, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
